// File: rtl/quad_step_counter.sv
`default_nettype none
// ============================================================================
// quad_step_counter
//   Quadrature decoder with synchronised phase inputs and an up/down counter
//   with clear, load and double-bit error reporting.
//   Optional macro QSC_SATURATE_EN: saturate at 0 / all ones instead of wrap.
//   Revision: 1.0
// ============================================================================
module quad_step_counter #(
  parameter int width       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             QA,
  input  logic             QB,
  input  logic             ClrEn,
  input  logic             LoadEn,
  input  logic [width-1:0] LoadVal,
  output logic [width-1:0] Cnt,
  output logic             DecEn,
  output logic             Step,
  output logic             Err
);

  localparam logic [width-1:0] c_one      = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] c_all_ones = {width{1'b1}};

  logic [SYNC_STAGES-1:0] r_sync_a;
  logic [SYNC_STAGES-1:0] r_sync_b;
  logic [SYNC_STAGES-1:0] r_fill;
  logic                   r_init;
  logic [1:0]             r_prev;
  logic [1:0]             w_cur;
  logic                   w_fwd;
  logic                   w_rev;
  logic                   w_dbl;
  logic [width-1:0]       w_cnt_next;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
      r_fill   <= '0;
    end else begin
      r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], QA};
      r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], QB};
      r_fill   <= {r_fill[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign w_cur = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};

  always_comb begin
    w_fwd = 1'b0;
    w_rev = 1'b0;
    w_dbl = 1'b0;
    if (r_init) begin
      case ({r_prev, w_cur})
        4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_fwd = 1'b1;
        4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_rev = 1'b1;
        4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: w_dbl = 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_cnt_next = Cnt;
    if (ClrEn) begin
      w_cnt_next = '0;
    end else if (LoadEn) begin
      w_cnt_next = LoadVal;
    end else if (w_fwd) begin
`ifdef QSC_SATURATE_EN
      if (Cnt != c_all_ones) w_cnt_next = Cnt + c_one;
`else
      w_cnt_next = Cnt + c_one;
`endif
    end else if (w_rev) begin
`ifdef QSC_SATURATE_EN
      if (Cnt != '0) w_cnt_next = Cnt - c_one;
`else
      w_cnt_next = Cnt - c_one;
`endif
    end
  end

  // Decoding arms only once the synchroniser holds post-reset samples, so
  // phases already high at reset release never look like a transition.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_init <= 1'b0;
      r_prev <= 2'b00;
      Cnt    <= '0;
      DecEn  <= 1'b0;
      Step   <= 1'b0;
      Err    <= 1'b0;
    end else begin
      r_init <= r_init | r_fill[SYNC_STAGES-1];
      r_prev <= w_cur;
      Cnt    <= w_cnt_next;
      Step   <= w_fwd | w_rev;
      Err    <= w_dbl;
      if (w_fwd | w_rev) DecEn <= w_rev;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_quad_step_counter.sv
`default_nettype none
// Scoreboard bench for quad_step_counter: expected step/error events are
// queued when a phase change is driven and popped when the DUT reports it.
module tb_quad_step_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       QA = 1'b0, QB = 1'b0;
  logic       ClrEn = 1'b0, LoadEn = 1'b0;
  logic [7:0] LoadVal = 8'h00;
  logic [7:0] Cnt;
  logic       DecEn, Step, Err;

  int passed = 0;
  int total  = 0;

  logic [7:0] exp_cnt = 8'h00;
  logic       exp_dec = 1'b0;

  typedef struct {
    logic [7:0] cnt;
    logic       dec;
    logic       err;
  } exp_t;
  exp_t sbq[$];

  quad_step_counter #(.width(8), .SYNC_STAGES(2)) dut (
    .CLK(CLK), .RST(RST), .QA(QA), .QB(QB),
    .ClrEn(ClrEn), .LoadEn(LoadEn), .LoadVal(LoadVal),
    .Cnt(Cnt), .DecEn(DecEn), .Step(Step), .Err(Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] f_inc(input logic [7:0] v);
`ifdef QSC_SATURATE_EN
    return (v == 8'hFF) ? v : v + 8'd1;
`else
    return v + 8'd1;
`endif
  endfunction

  function automatic logic [7:0] f_dec(input logic [7:0] v);
`ifdef QSC_SATURATE_EN
    return (v == 8'h00) ? v : v - 8'd1;
`else
    return v - 8'd1;
`endif
  endfunction

  // kind: 0 = forward step, 1 = reverse step, 2 = illegal double-bit jump
  task automatic apply(input logic a, input logic b, input int kind, input string nm);
    exp_t e, got;
    int   lat;
    bit   seen;
    if (kind == 0) begin exp_cnt = f_inc(exp_cnt); exp_dec = 1'b0; end
    else if (kind == 1) begin exp_cnt = f_dec(exp_cnt); exp_dec = 1'b1; end
    e.cnt = exp_cnt; e.dec = exp_dec; e.err = (kind == 2);
    sbq.push_back(e);
    QA = a; QB = b;
    seen = 1'b0; lat = 0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      tick();
      if (Step || Err) begin seen = 1'b1; lat = i; end
    end
    got = sbq.pop_front();
    total++;
    if (!seen) $display("FAIL %s_event: no Step/Err within 8 cycles, required one", nm);
    else passed++;
    if (seen) begin
      total++;
      if (lat !== 3) $display("FAIL %s_latency: got %0d cycles, required 3", nm, lat);
      else passed++;
      total++;
      if (Err !== got.err || Step !== !got.err)
        $display("FAIL %s_kind: Step=%b Err=%b, required Step=%b Err=%b", nm, Step, Err, !got.err, got.err);
      else passed++;
      total++;
      if (Cnt !== got.cnt) $display("FAIL %s_cnt: got %h, required %h", nm, Cnt, got.cnt);
      else passed++;
      total++;
      if (DecEn !== got.dec) $display("FAIL %s_dec: got %b, required %b", nm, DecEn, got.dec);
      else passed++;
      tick();
      total++;
      if (Step !== 1'b0 || Err !== 1'b0)
        $display("FAIL %s_pulse: Step=%b Err=%b one cycle later, required 0 0", nm, Step, Err);
      else passed++;
    end
  endtask

  task automatic do_clear(input string nm);
    ClrEn = 1'b1;
    tick();
    ClrEn = 1'b0;
    exp_cnt = 8'h00;
    total++;
    if (Cnt !== 8'h00) $display("FAIL %s: got %h, required 00", nm, Cnt);
    else passed++;
  endtask

  task automatic test_reset();
    int ev;
    QA = 1'b1; QB = 1'b1; RST = 1'b1;
    repeat (3) tick();
    total++;
    if (Cnt !== 8'h00 || DecEn !== 1'b0 || Step !== 1'b0 || Err !== 1'b0)
      $display("FAIL reset_outputs: Cnt=%h DecEn=%b Step=%b Err=%b, required 00 0 0 0", Cnt, DecEn, Step, Err);
    else passed++;
    RST = 1'b0;
    ev = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (Step || Err) ev++;
    end
    total++;
    if (ev !== 0) $display("FAIL reset_release_quiet: got %0d Step/Err pulses, required 0", ev);
    else passed++;
    total++;
    if (Cnt !== 8'h00) $display("FAIL reset_release_cnt: got %h, required 00", Cnt);
    else passed++;
    apply(1'b0, 1'b1, 0, "post_reset_11_01");
    apply(1'b0, 1'b0, 0, "post_reset_01_00");
    do_clear("reset_clear");
  endtask

  task automatic test_forward();
    apply(1'b1, 1'b0, 0, "fwd_00_10");
    apply(1'b1, 1'b1, 0, "fwd_10_11");
    apply(1'b0, 1'b1, 0, "fwd_11_01");
    apply(1'b0, 1'b0, 0, "fwd_01_00");
  endtask

  task automatic test_wrap();
    LoadVal = 8'hFF; LoadEn = 1'b1;
    tick();
    LoadEn = 1'b0;
    exp_cnt = 8'hFF;
    total++;
    if (Cnt !== 8'hFF) $display("FAIL load_ff: got %h, required ff", Cnt);
    else passed++;
    apply(1'b1, 1'b0, 0, "wrap_up");
  endtask

  task automatic test_reverse();
    do_clear("rev_clear");
    apply(1'b0, 1'b0, 1, "rev_10_00_under");
    apply(1'b0, 1'b1, 1, "rev_00_01");
  endtask

  task automatic test_error();
    apply(1'b1, 1'b0, 2, "err_01_10");
    apply(1'b0, 1'b0, 1, "rev_10_00");
    apply(1'b1, 1'b1, 2, "err_00_11");
    apply(1'b0, 1'b1, 0, "fwd_11_01_after_err");
  endtask

  task automatic test_priority();
    QA = 1'b0; QB = 1'b0;
    tick(); tick();
    ClrEn = 1'b1; LoadEn = 1'b1; LoadVal = 8'h55;
    tick();
    ClrEn = 1'b0; LoadEn = 1'b0;
    exp_cnt = 8'h00; exp_dec = 1'b0;
    total++;
    if (Cnt !== 8'h00 || Step !== 1'b1)
      $display("FAIL clr_over_step: Cnt=%h Step=%b, required 00 1", Cnt, Step);
    else passed++;
    total++;
    if (DecEn !== 1'b0) $display("FAIL clr_step_dec: got %b, required 0", DecEn);
    else passed++;
    tick();
    QA = 1'b1; QB = 1'b0;
    tick(); tick();
    LoadEn = 1'b1; LoadVal = 8'h55;
    tick();
    LoadEn = 1'b0;
    exp_cnt = 8'h55;
    total++;
    if (Cnt !== 8'h55 || Step !== 1'b1)
      $display("FAIL load_over_step: Cnt=%h Step=%b, required 55 1", Cnt, Step);
    else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int ev;
    QA = 1'b1; QB = 1'b1;
    tick();
    total++;
    if (Cnt !== exp_cnt) $display("FAIL pre_reset_cnt: got %h, required %h", Cnt, exp_cnt);
    else passed++;
    #3;
    RST = 1'b1;
    #1;
    total++;
    if (Cnt !== 8'h00 || DecEn !== 1'b0 || Step !== 1'b0 || Err !== 1'b0)
      $display("FAIL async_reset: Cnt=%h DecEn=%b Step=%b Err=%b, required 00 0 0 0", Cnt, DecEn, Step, Err);
    else passed++;
    tick();
    RST = 1'b0;
    ev = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Step || Err) ev++;
    end
    total++;
    if (ev !== 0 || Cnt !== 8'h00)
      $display("FAIL rearm_quiet: pulses=%0d Cnt=%h, required 0 00", ev, Cnt);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_forward();
    test_wrap();
    test_reverse();
    test_error();
    test_priority();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
